// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-subset core with a single unified memory port.
// A control FSM sequences one shared datapath through 3-5 states per instruction.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic [31:0]       pc_dbg,
    output logic              halted,
    output logic [1:0]        trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] wcnt_q, wcnt_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] rf_q [32];

    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [31:0] sext;
    logic [31:0] rd_a, rd_b;
    logic        is_r, is_addi, is_lw, is_sw, is_beq, is_j;
    logic        op_ok, fn_ok;
    logic [31:0] alu_b, alu_res, ea;
    logic        to_hit;
    logic        unused_shamt;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign funct = ir_q[5:0];
    assign sext  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign unused_shamt = ^ir_q[10:6];

    assign is_r    = (op == 6'h00);
    assign is_addi = (op == 6'h08);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    assign is_beq  = (op == 6'h04);
    assign is_j    = (op == 6'h02);
    assign op_ok   = is_r | is_addi | is_lw | is_sw | is_beq | is_j;

    assign rd_a  = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rd_b  = (rt == 5'd0) ? 32'd0 : rf_q[rt];
    assign alu_b = is_r ? b_q : sext;
    assign ea    = a_q + sext;

    // The wait that would bring the count to the limit traps; ready wins.
    assign to_hit = (WAIT_TIMEOUT != 0) &&
                    ((wcnt_q + 32'd1) >= WAIT_TIMEOUT);

    always_comb begin
        alu_res = a_q + alu_b;
        fn_ok   = 1'b1;
        if (is_r) begin
            unique case (funct)
                6'h20: alu_res = a_q + b_q;
                6'h22: alu_res = a_q - b_q;
                6'h24: alu_res = a_q & b_q;
                6'h25: alu_res = a_q | b_q;
                6'h2A: alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
                default: fn_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        wcnt_d    = wcnt_q;
        cause_d   = cause_q;
        rf_we     = 1'b0;
        rf_wa     = is_r ? rd : rt;
        rf_wd     = is_lw ? mdr_q : alu_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q[ADDR_W-1:0];
        mem_wdata = b_q;
        retire    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    wcnt_d  = 32'd0;
                    state_d = S_DECODE;
                end else begin
                    wcnt_d = wcnt_q + 32'd1;
                    if (to_hit) begin
                        cause_d = 2'b11;
                        state_d = S_TRAP;
                    end
                end
            end
            S_DECODE: begin
                a_d   = rd_a;
                b_d   = rd_b;
                alu_d = pc_q + {sext[29:0], 2'b00};
                if (op_ok) begin
                    state_d = S_EXEC;
                end else begin
                    cause_d = 2'b01;
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_lw, is_sw: begin
                        alu_d = ea;
                        if (ea[1:0] != 2'b00) begin
                            cause_d = 2'b10;
                            state_d = S_TRAP;
                        end else begin
                            wcnt_d  = 32'd0;
                            state_d = S_MEM;
                        end
                    end
                    is_beq: begin
                        if (a_q == b_q) pc_d = alu_q;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    is_j: begin
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        if (fn_ok) begin
                            alu_d   = alu_res;
                            state_d = S_WB;
                        end else begin
                            cause_d = 2'b01;
                            state_d = S_TRAP;
                        end
                    end
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_sw;
                mem_addr = alu_q[ADDR_W-1:0];
                if (mem_ready) begin
                    wcnt_d = 32'd0;
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end else begin
                    wcnt_d = wcnt_q + 32'd1;
                    if (to_hit) begin
                        cause_d = 2'b11;
                        state_d = S_TRAP;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        // Reset parks the FSM in FETCH, so the request is masked here.
        mem_req = mem_req & reset;
        mem_we  = mem_we & reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            mdr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            wcnt_q  <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            wcnt_q  <= wcnt_d;
            cause_q <= cause_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we && rf_wa != 5'd0) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    assign pc_dbg     = pc_q;
    assign halted     = (state_q == S_TRAP);
    assign trap_cause = cause_q;

endmodule
